// File: rtl/renkon_pkg.sv
// Shared renkon datapath helpers: default widths, adder-tree sizing and
// fixed-point shift / width-reduction functions on a 64-bit carrier.
package renkon_pkg;

  localparam int DEF_DWIDTH = 16;
  localparam int DEF_LWIDTH = 5;
  localparam int MAXW       = 64;

  function automatic int tree_depth(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  // Element count at tree level l (each level halves, rounding up).
  function automatic int level_count(input int n, input int l);
    int c;
    c = n;
    for (int i = 0; i < l; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Arithmetic right shift: floors toward -inf.
  function automatic logic signed [MAXW-1:0] asr_floor(input logic signed [MAXW-1:0] x,
                                                       input int unsigned sh);
    return x >>> sh;
  endfunction

  function automatic logic signed [MAXW-1:0] wrap_shrink(input logic signed [MAXW-1:0] x,
                                                         input int iw, input int ow);
    logic signed [MAXW-1:0] t;
    t = (x << (MAXW - iw)) >>> (MAXW - iw);
    return (t << (MAXW - ow)) >>> (MAXW - ow);
  endfunction

  function automatic logic signed [MAXW-1:0] sat_shrink(input logic signed [MAXW-1:0] x,
                                                        input int iw, input int ow);
    logic signed [MAXW-1:0] t, hi, lo;
    t  = (x << (MAXW - iw)) >>> (MAXW - iw);
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (t > hi) return hi;
    if (t < lo) return lo;
    return t;
  endfunction

endpackage

// File: rtl/renkon_conv_tree_acc_if.sv
// Sample/result bus between the window/weight feeder and the conv tree.
interface renkon_conv_tree_acc_if #(
  parameter int DWIDTH = 16,
  parameter int LWIDTH = 5,
  parameter int N      = 25
);
  logic                     in_valid;
  logic                     in_last;
  logic [LWIDTH-1:0]        qbits;
  logic signed [DWIDTH-1:0] pixel  [N];
  logic signed [DWIDTH-1:0] weight [N];
  logic                     out_valid;
  logic signed [DWIDTH-1:0] fmap;

  modport master (output in_valid, in_last, qbits, pixel, weight,
                  input  out_valid, fmap);
  modport slave  (input  in_valid, in_last, qbits, pixel, weight,
                  output out_valid, fmap);
endinterface

// File: rtl/renkon_adder_stage.sv
// One registered adder-tree level: M signed inputs -> ceil(M/2) sums of W+1 bits.
module renkon_adder_stage #(
  parameter int M      = 2,
  parameter int W      = 16,
  parameter int LWIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [M-1:0][W-1:0]       in_d,
  input  logic                      in_vld,
  input  logic                      in_last,
  input  logic [LWIDTH-1:0]         in_qb,
  output logic [(M+1)/2-1:0][W:0]   out_d,
  output logic                      out_vld,
  output logic                      out_last,
  output logic [LWIDTH-1:0]         out_qb
);
  localparam int MO = (M + 1) / 2;

  logic [MO-1:0][W:0] nxt;

  for (genvar j = 0; j < MO; j++) begin : g_pair
    if (2*j + 1 < M) begin : g_add
      assign nxt[j] = (W+1)'($signed(in_d[2*j])) + (W+1)'($signed(in_d[2*j+1]));
    end else begin : g_pass
      assign nxt[j] = (W+1)'($signed(in_d[2*j]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_d    <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_qb   <= '0;
    end else begin
      out_d    <= nxt;
      out_vld  <= in_vld;
      out_last <= in_last;
      out_qb   <= in_qb;
    end
  end
endmodule

// File: rtl/renkon_conv_tree_acc.sv
// KSIZE*KSIZE multiply / qbits-rescale / registered adder tree / channel accumulator.
// Define RENKON_TREE_SAT_EN to saturate (instead of wrap) the S3 and output reductions.
module renkon_conv_tree_acc
  import renkon_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int LWIDTH = DEF_LWIDTH,
  parameter int KSIZE  = 5
) (
  input logic                    clk,
  input logic                    rst,
  renkon_conv_tree_acc_if.slave  bus
);
  localparam int N    = KSIZE * KSIZE;
  localparam int L    = tree_depth(N);
  localparam int PW   = 2 * DWIDTH;
  localparam int TW   = DWIDTH + L;
  localparam int ACCW = TW + 8;

  // Sidebands for S1..S3; index 0 is S1.
  logic [2:0]              vld_pipe, last_pipe;
  logic [2:0][LWIDTH-1:0]  qb_pipe;
  logic signed [DWIDTH-1:0] s1_pix [N];
  logic signed [DWIDTH-1:0] s1_wt  [N];
  logic signed [PW-1:0]     s2_prod [N];
  logic [N-1:0][DWIDTH-1:0] s3_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      qb_pipe   <= '0;
      s3_d      <= '0;
      for (int i = 0; i < N; i++) begin
        s1_pix[i]  <= '0;
        s1_wt[i]   <= '0;
        s2_prod[i] <= '0;
      end
    end else begin
      vld_pipe  <= {vld_pipe[1:0],  bus.in_valid};
      last_pipe <= {last_pipe[1:0], bus.in_last};
      qb_pipe   <= {qb_pipe[1:0],   bus.qbits};
      for (int i = 0; i < N; i++) begin
        s1_pix[i]  <= bus.pixel[i];
        s1_wt[i]   <= bus.weight[i];
        s2_prod[i] <= s1_pix[i] * s1_wt[i];
`ifdef RENKON_TREE_SAT_EN
        s3_d[i] <= DWIDTH'(sat_shrink(asr_floor(64'(s2_prod[i]), int'(qb_pipe[1])), PW, DWIDTH));
`else
        s3_d[i] <= DWIDTH'(wrap_shrink(asr_floor(64'(s2_prod[i]), int'(qb_pipe[1])), PW, DWIDTH));
`endif
      end
    end
  end

  // Per-level tree buses; level 0 is the scaled-product register bank.
  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int M = level_count(N, l);
    logic [M-1:0][DWIDTH+l-1:0] d;
    logic                       v;
    logic                       lst;
    logic [LWIDTH-1:0]          qb;
    if (l == 0) begin : g_src
      assign d   = s3_d;
      assign v   = vld_pipe[2];
      assign lst = last_pipe[2];
      assign qb  = qb_pipe[2];
    end
  end

  for (genvar l = 0; l < L; l++) begin : g_stg
    renkon_adder_stage #(
      .M      (level_count(N, l)),
      .W      (DWIDTH + l),
      .LWIDTH (LWIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_d     (g_lvl[l].d),
      .in_vld   (g_lvl[l].v),
      .in_last  (g_lvl[l].lst),
      .in_qb    (g_lvl[l].qb),
      .out_d    (g_lvl[l+1].d),
      .out_vld  (g_lvl[l+1].v),
      .out_last (g_lvl[l+1].lst),
      .out_qb   (g_lvl[l+1].qb)
    );
  end

  logic signed [TW-1:0]   tree_root;
  logic [LWIDTH-1:0]      unused_qb;
  logic signed [ACCW-1:0] acc, sum;
  logic signed [DWIDTH-1:0] fmap_q;
  logic                   out_valid_q;

  assign tree_root = g_lvl[L].d[0];
  assign unused_qb = g_lvl[L].qb;
  assign sum       = acc + ACCW'(tree_root);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      fmap_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (g_lvl[L].v) begin
        if (g_lvl[L].lst) begin
`ifdef RENKON_TREE_SAT_EN
          fmap_q <= DWIDTH'(sat_shrink(64'(sum), ACCW, DWIDTH));
`else
          fmap_q <= DWIDTH'(wrap_shrink(64'(sum), ACCW, DWIDTH));
`endif
          out_valid_q <= 1'b1;
          acc         <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.fmap      = fmap_q;
endmodule
